// File: rtl/fetch_queue_pkg.sv
// Shared types for the dual-issue fetch queue: entry layout and widths.
// Optional stall statistics are enabled by FETCH_QUEUE_STATS_EN.
package superleg_pkg;

  localparam int PC_W   = 64;
  localparam int INST_W = 32;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

  // Illegal 2'b10 collapses to zero entries.
  function automatic logic [1:0] pair_cnt(input logic [1:0] v);
    logic [1:0] n;
    unique case (1'b1)
      (v == 2'b11): n = 2'd2;
      (v == 2'b01): n = 2'd1;
      default:      n = 2'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch-side and decode-side handshake bundle of the fetch queue.
// Optional stall statistics are enabled by FETCH_QUEUE_STATS_EN.
interface fetch_queue_if #(
  parameter int DEPTH = 8
);
  import superleg_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;

  logic [1:0]        in_valid;
  logic [PC_W-1:0]   in_pc0;
  logic [PC_W-1:0]   in_pc1;
  logic [INST_W-1:0] in_inst0;
  logic [INST_W-1:0] in_inst1;
  logic              in_ready;
  logic [1:0]        out_valid;
  logic [PC_W-1:0]   out_pc0;
  logic [PC_W-1:0]   out_pc1;
  logic [INST_W-1:0] out_inst0;
  logic [INST_W-1:0] out_inst1;
  logic [1:0]        out_pop;
  logic              flush;
  logic [CW-1:0]     count;

  modport master (
    output in_valid, in_pc0, in_pc1,
    output in_inst0, in_inst1,
    output out_pop, flush,
    input  in_ready, out_valid,
    input  out_pc0, out_pc1,
    input  out_inst0, out_inst1, count
  );

  modport slave (
    input  in_valid, in_pc0, in_pc1,
    input  in_inst0, in_inst1,
    input  out_pop, flush,
    output in_ready, out_valid,
    output out_pc0, out_pc1,
    output out_inst0, out_inst1, count
  );

endinterface

// File: rtl/fetch_queue_ram.sv
// Entry storage: two synchronous write ports, two asynchronous read ports.
// Optional stall statistics are enabled by FETCH_QUEUE_STATS_EN.
module fetch_queue_ram
  import superleg_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic         clk_i,
  input  logic         we0_i,
  input  logic [AW-1:0] waddr0_i,
  input  fetch_entry_t wdata0_i,
  input  logic         we1_i,
  input  logic [AW-1:0] waddr1_i,
  input  fetch_entry_t wdata1_i,
  input  logic [AW-1:0] raddr0_i,
  output fetch_entry_t rdata0_o,
  input  logic [AW-1:0] raddr1_i,
  output fetch_entry_t rdata1_o
);

  fetch_entry_t mem_q [DEPTH];

  // Write addresses are always tail and tail+1, so they never collide.
  always_ff @(posedge clk_i) begin
    if (we0_i) mem_q[waddr0_i] <= wdata0_i;
    if (we1_i) mem_q[waddr1_i] <= wdata1_i;
  end

  assign rdata0_o = mem_q[raddr0_i];
  assign rdata1_o = mem_q[raddr1_i];

endmodule

// File: rtl/fetch_queue.sv
// Dual-issue fetch queue between fetch and IF/ID decode.
// Define FETCH_QUEUE_STATS_EN to add saturating stall counters.
module fetch_queue
  import superleg_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic        CLOCK,
  input  logic        RESET,
`ifdef FETCH_QUEUE_STATS_EN
  output logic [31:0] stall_empty_cnt,
  output logic [31:0] stall_full_cnt,
`endif
  fetch_queue_if.slave fq
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [1:0]    push_n, pop_n;
  logic          ready;
  logic          we0, we1;
  fetch_entry_t  wdata0, wdata1;
  fetch_entry_t  rdata0, rdata1;

  // Registered count only: same-cycle pops earn no credit.
  assign ready = count_q <= CW'(DEPTH - 2);

  always_comb begin
    push_n = ready ? pair_cnt(fq.in_valid) : 2'd0;
    pop_n  = pair_cnt(fq.out_pop);
    if (CW'(pop_n) > count_q) pop_n = count_q[1:0];
    head_d  = head_q + AW'(pop_n);
    tail_d  = tail_q + AW'(push_n);
    count_d = count_q + CW'(push_n) - CW'(pop_n);
    if (fq.flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign we0    = (push_n != 2'd0) && !fq.flush && !RESET;
  assign we1    = (push_n == 2'd2) && !fq.flush && !RESET;
  assign wdata0 = '{pc: fq.in_pc0, inst: fq.in_inst0};
  assign wdata1 = '{pc: fq.in_pc1, inst: fq.in_inst1};

  fetch_queue_ram #(
    .DEPTH (DEPTH)
  ) u_ram (
    .clk_i    (CLOCK),
    .we0_i    (we0),
    .waddr0_i (tail_q),
    .wdata0_i (wdata0),
    .we1_i    (we1),
    .waddr1_i (tail_q + AW'(1)),
    .wdata1_i (wdata1),
    .raddr0_i (head_q),
    .rdata0_o (rdata0),
    .raddr1_i (head_q + AW'(1)),
    .rdata1_o (rdata1)
  );

  assign fq.in_ready     = ready;
  assign fq.count        = count_q;
  assign fq.out_valid[0] = count_q >= CW'(1);
  assign fq.out_valid[1] = count_q >= CW'(2);
  assign fq.out_pc0   = fq.out_valid[0] ? rdata0.pc   : '0;
  assign fq.out_inst0 = fq.out_valid[0] ? rdata0.inst : '0;
  assign fq.out_pc1   = fq.out_valid[1] ? rdata1.pc   : '0;
  assign fq.out_inst1 = fq.out_valid[1] ? rdata1.inst : '0;

`ifdef FETCH_QUEUE_STATS_EN
  logic [31:0] stall_empty_q;
  logic [31:0] stall_full_q;

  // Flush does not clear these; only RESET does.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      stall_empty_q <= '0;
      stall_full_q  <= '0;
    end else begin
      if (count_q == '0 && !fq.flush && stall_empty_q != '1)
        stall_empty_q <= stall_empty_q + 32'd1;
      if (fq.in_valid != 2'b00 && !ready && stall_full_q != '1)
        stall_full_q <= stall_full_q + 32'd1;
    end
  end

  assign stall_empty_cnt = stall_empty_q;
  assign stall_full_cnt  = stall_full_q;
`endif

`ifndef SYNTHESIS
  a_in_valid: assert property (@(posedge CLOCK) disable iff (RESET)
    fq.in_valid != 2'b10);
  a_out_pop: assert property (@(posedge CLOCK) disable iff (RESET || fq.flush)
    fq.out_pop != 2'b10 &&
    !(fq.out_pop[0] && !fq.out_valid[0]) &&
    !(fq.out_pop[1] && !fq.out_valid[1]));
`endif

endmodule
